// File: rtl/iterative_divider.sv
// Multi-cycle restoring integer divider (RISC-V DIV/DIVU/REM/REMU semantics), 1/2/4 quotient bits per clock.
// Optional macro DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module iterative_divider #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signed_div,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) begin : g_bad_bpc
            $error("iterative_divider: BITS_PER_CYCLE must be 1, 2 or 4");
        end
        if (WIDTH < 8 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_width
            $error("iterative_divider: WIDTH must be >= 8 and divisible by BITS_PER_CYCLE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    count;
    logic             q_neg;
    logic             r_neg;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             overflow;
    logic             early_out;

    assign a_neg    = signed_div & dividend[WIDTH-1];
    assign b_neg    = signed_div & divisor[WIDTH-1];
    assign a_mag    = a_neg ? (~dividend + 1'b1) : dividend;
    assign b_mag    = b_neg ? (~divisor + 1'b1) : divisor;
    assign div_zero = (divisor == '0);
    assign overflow = signed_div && (dividend == MIN_VAL) && (divisor == '1);

`ifdef DIV_EARLY_OUT_EN
    assign early_out = (b_mag != '0) && (a_mag < b_mag);
`else
    assign early_out = 1'b0;
`endif

    // Unrolled restoring steps; the shifted-out rem MSB forces a 1 because rem then exceeds any divisor.
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] num_step;
    logic             msb;
    logic [WIDTH:0]   trial;

    always_comb begin
        rem_step = rem;
        num_step = num;
        msb      = 1'b0;
        trial    = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            msb      = rem_step[WIDTH-1];
            rem_step = {rem_step[WIDTH-2:0], num_step[WIDTH-1]};
            num_step = {num_step[WIDTH-2:0], 1'b0};
            trial    = {1'b0, rem_step} - {1'b0, dvsr};
            if (!trial[WIDTH] || msb) begin
                rem_step    = trial[WIDTH-1:0];
                num_step[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            quotient  <= '0;
            remainder <= '0;
            count     <= '0;
            rem       <= '0;
            num       <= '0;
            dvsr      <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q_neg <= a_neg ^ b_neg;
                        r_neg <= a_neg;
                        num   <= a_mag;
                        dvsr  <= b_mag;
                        rem   <= '0;
                        count <= '0;
                        if (div_zero) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            state     <= DONE;
                        end else if (overflow) begin
                            quotient  <= MIN_VAL;
                            remainder <= '0;
                            state     <= DONE;
                        end else if (early_out) begin
                            quotient  <= '0;
                            remainder <= dividend;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem   <= rem_step;
                    num   <= num_step;
                    count <= count + 1'b1;
                    if (count == CW'(N - 1)) begin
                        quotient  <= q_neg ? (~num_step + 1'b1) : num_step;
                        remainder <= r_neg ? (~rem_step + 1'b1) : rem_step;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_iterative_divider.sv
// Directed and model-checked bench driving three dividers (1, 2 and 4 bits per cycle) in lockstep.
module tb_iterative_divider;
    localparam int NORMAL  = 0;
    localparam int SPECIAL = 1;
    localparam int EARLY   = 2;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        signed_div;
    logic        out_ready;

    logic        ir [3];
    logic        ov [3];
    logic        bz [3];
    logic [31:0] q  [3];
    logic [31:0] r  [3];

    int bpc [3] = '{1, 2, 4};
    int errors = 0;
    int checks = 0;

    iterative_divider #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_div1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .dividend(dividend), .divisor(divisor), .signed_div(signed_div), .out_valid(ov[0]),
        .out_ready(out_ready), .quotient(q[0]), .remainder(r[0]), .busy(bz[0]));
    iterative_divider #(.WIDTH(32), .BITS_PER_CYCLE(2)) u_div2 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .dividend(dividend), .divisor(divisor), .signed_div(signed_div), .out_valid(ov[1]),
        .out_ready(out_ready), .quotient(q[1]), .remainder(r[1]), .busy(bz[1]));
    iterative_divider #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_div4 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .dividend(dividend), .divisor(divisor), .signed_div(signed_div), .out_valid(ov[2]),
        .out_ready(out_ready), .quotient(q[2]), .remainder(r[2]), .busy(bz[2]));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input int kind, input int k);
        if (kind == SPECIAL) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (kind == EARLY) return 1;
`endif
        return 32 / bpc[k] + 1;
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ir[0] && ir[1] && ir[2]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check($sformatf("%s_idle_timeout", name), 64'd0, 64'd1);
    endtask

    // driver: issues one operation on all three instances, scrambles inputs after accept
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                          input int kind, input bit hold);
        bit          seen [3] = '{0, 0, 0};
        int          lat  [3] = '{0, 0, 0};
        logic [31:0] cq   [3] = '{0, 0, 0};
        logic [31:0] cr   [3] = '{0, 0, 0};
        wait_idle(name);
        dividend   = a;
        divisor    = b;
        signed_div = sgn;
        in_valid   = 1'b1;
        out_ready  = !hold;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        dividend   = $urandom;
        divisor    = $urandom;
        signed_div = 1'($urandom_range(0, 1));
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!seen[k] && ov[k]) begin
                    seen[k] = 1;
                    lat[k]  = c;
                    cq[k]   = q[k];
                    cr[k]   = r[k];
                end
            end
            if (seen[0] && seen[1] && seen[2]) break;
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_q_bpc%0d", name, bpc[k]), 64'(cq[k]), 64'(eq));
            check($sformatf("%s_r_bpc%0d", name, bpc[k]), 64'(cr[k]), 64'(er));
            check($sformatf("%s_lat_bpc%0d", name, bpc[k]), 64'(lat[k]), 64'(exp_lat(kind, k)));
        end
        if (hold) begin
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                check($sformatf("%s_hold_valid", name), 64'(ov[0]), 64'd1);
                check($sformatf("%s_hold_q", name), 64'(q[0]), 64'(eq));
                check($sformatf("%s_hold_r", name), 64'(r[0]), 64'(er));
            end
            out_ready = 1'b1;
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                check($sformatf("%s_release_ready_bpc%0d", name, bpc[k]), 64'(ir[k]), 64'd1);
                check($sformatf("%s_release_valid_bpc%0d", name, bpc[k]), 64'(ov[k]), 64'd0);
            end
        end
    endtask

    task automatic start_long_op();
        wait_idle("start");
        dividend   = 32'd1000;
        divisor    = 32'd3;
        signed_div = 1'b0;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
    endtask

    initial begin
        logic [31:0] a, b, eq, er;
        logic        sgn;
        int          kind;

        reset      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        dividend   = '0;
        divisor    = '0;
        signed_div = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_q_bpc%0d", bpc[k]), 64'(q[k]), 64'd0);
            check($sformatf("rst_r_bpc%0d", bpc[k]), 64'(r[k]), 64'd0);
            check($sformatf("rst_ready_bpc%0d", bpc[k]), 64'(ir[k]), 64'd1);
            check($sformatf("rst_valid_bpc%0d", bpc[k]), 64'(ov[k]), 64'd0);
            check($sformatf("rst_busy_bpc%0d", bpc[k]), 64'(bz[k]), 64'd0);
        end
        reset = 1'b1;

        // directed vectors, hand-computed
        run_op("u100_7",    32'd100,        32'd7,          1'b0, 32'd14,       32'd2,        NORMAL,  1);
        run_op("sm100_7",   32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, NORMAL,  0);
        run_op("s100_m7",   32'd100,        32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2, 32'd2,        NORMAL,  0);
        run_op("div0",      32'h00001234,   32'd0,          1'b0, 32'hFFFFFFFF, 32'h00001234, SPECIAL, 0);
        run_op("sdiv0",     32'hFFFFFFF0,   32'd0,          1'b1, 32'hFFFFFFFF, 32'hFFFFFFF0, SPECIAL, 0);
        run_op("ovf",       32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000, 32'd0,        SPECIAL, 0);
        run_op("u5_9",      32'd5,          32'd9,          1'b0, 32'd0,        32'd5,        EARLY,   0);
        run_op("umax_1",    32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF, 32'd0,        NORMAL,  0);
        run_op("umin_umax", 32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,        32'h80000000, EARLY,   0);
        run_op("sm7_m100",  32'hFFFFFFF9,   32'hFFFFFF9C,   1'b1, 32'd0,        32'hFFFFFFF9, EARLY,   0);

        // flush during CALC
        start_long_op();
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                check($sformatf("flush_valid_bpc%0d", bpc[k]), 64'(ov[k]), 64'd0);
                check($sformatf("flush_ready_bpc%0d", bpc[k]), 64'(ir[k]), 64'd1);
            end
        end
        run_op("after_flush_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, NORMAL, 0);

        // reset mid-CALC
        run_op("u1000_7", 32'd1000, 32'd7, 1'b0, 32'd142, 32'd6, NORMAL, 0);
        start_long_op();
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("midrst_q_bpc%0d", bpc[k]), 64'(q[k]), 64'd0);
            check($sformatf("midrst_r_bpc%0d", bpc[k]), 64'(r[k]), 64'd0);
            check($sformatf("midrst_valid_bpc%0d", bpc[k]), 64'(ov[k]), 64'd0);
            check($sformatf("midrst_ready_bpc%0d", bpc[k]), 64'(ir[k]), 64'd1);
            check($sformatf("midrst_busy_bpc%0d", bpc[k]), 64'(bz[k]), 64'd0);
        end

        // randomized, against a behavioural reference model
        for (int i = 0; i < 24; i++) begin
            a   = $urandom;
            b   = $urandom;
            sgn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: a = 32'($urandom_range(0, 1000));
                4: b = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
                default: ;
            endcase
            if (b == 32'd0) begin
                eq = 32'hFFFFFFFF; er = a; kind = SPECIAL;
            end else if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                eq = 32'h80000000; er = 32'd0; kind = SPECIAL;
            end else if (sgn) begin
                eq   = $signed(a) / $signed(b);
                er   = $signed(a) % $signed(b);
                kind = (mag(a, 1'b1) < mag(b, 1'b1)) ? EARLY : NORMAL;
            end else begin
                eq   = a / b;
                er   = a % b;
                kind = (a < b) ? EARLY : NORMAL;
            end
            run_op($sformatf("rand%0d", i), a, b, sgn, eq, er, kind, 0);
        end

        // report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/iterative_divider.md
# iterative_divider

Parametrised multi-cycle integer divider for the EX stage, the next generation of the fixed 32-bit radix-2 restoring divider. It adds configurable operand width, 1/2/4 quotient bits retired per cycle, valid/ready handshakes on both sides, a flush input, and RISC-V M-extension results for divide-by-zero and signed overflow. The pipeline hazard logic issues DIV/DIVU/REM/REMU operations to it and stalls until the result handshake completes.

## Interface
- `WIDTH`, 32: operand and result width. Must be ≥ 8 and divisible by `BITS_PER_CYCLE`.
- `BITS_PER_CYCLE`, 1: restoring steps unrolled per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- `clk` input 1: the only clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low reset.
- `flush` input 1: abandons any in-flight or pending operation.
- `in_valid` input 1: operands are presented.
- `in_ready` output 1: the divider can accept operands.
- `dividend` input WIDTH: numerator.
- `divisor` input WIDTH: denominator.
- `signed_div` input 1: 1 selects two's-complement division, 0 selects unsigned.
- `out_valid` output 1: `quotient` and `remainder` are valid.
- `out_ready` input 1: the consumer takes the result.
- `quotient` output WIDTH: division result.
- `remainder` output WIDTH: division remainder.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- States are IDLE, CALC and DONE. `in_ready` = (state == IDLE); `out_valid` = (state == DONE).
- Reset (`reset` == 0) has top priority. Next state is IDLE. `quotient`, `remainder` and the iteration counter are cleared to 0. `out_valid` = 0, `busy` = 0, `in_ready` = 1.
- `flush` has second priority. Next state is IDLE from any state, and any operand presented in the same cycle is not accepted.
- Accept happens on `in_valid` && `in_ready` && !`flush`. On accept the block latches the magnitudes |dividend| and |divisor|, where the negation applies only when `signed_div` = 1 and the MSB is 1. It also latches `q_neg` = signed && (dividend MSB ^ divisor MSB) and `r_neg` = signed && dividend MSB.
- Special cases bypass CALC and go IDLE → DONE directly:
  - Divide by zero (`divisor` == 0): `quotient` = all ones, `remainder` = `dividend`.
  - Signed overflow (signed, `dividend` = MIN, `divisor` = all ones): `quotient` = MIN, `remainder` = 0.
- In CALC, each cycle performs `BITS_PER_CYCLE` restoring steps:
  - Shift {rem, num} left by 1.
  - Form a (WIDTH+1)-bit trial = rem − divisor.
  - The quotient bit is 1 if the trial did not borrow or the shifted-out rem MSB was 1; in that case rem takes the trial's low WIDTH bits.
  - The quotient bit shifts into the LSB of num.
- The counter counts to WIDTH/`BITS_PER_CYCLE` − 1, then the state moves to DONE.
- On entry to DONE:
  - `quotient` = `q_neg` ? −num : num.
  - `remainder` = `r_neg` ? −rem : rem.
  - Both are registered and held stable while DONE.
- DONE → IDLE on `out_ready`. A new operation cannot be accepted in that same cycle, because `in_ready` is still 0.
- `dividend`, `divisor` and `signed_div` are sampled only on the accept edge. Later changes to them have no effect on the operation in flight.

## Timing
- Let N = WIDTH/`BITS_PER_CYCLE`.
- For a normal operation, `out_valid` is first high N+1 cycles after the accept edge: the accept edge loads the operands, then N CALC edges run. Defaults give 33 cycles; `BITS_PER_CYCLE` = 4 gives 9.
- Special cases and early-out give `out_valid` one cycle after the accept edge.
- Minimum issue interval is N+2 cycles for normal operations and 2 cycles for special cases or early-out, assuming `out_ready` is held high.
- `flush` asserted in any cycle forces `out_valid` = 0 and `in_ready` = 1 from the next cycle.
- All outputs are registered or decoded from state. There is no combinational path from inputs to outputs.

## Configuration
- `DIV_EARLY_OUT_EN` defined: when |dividend| < |divisor| and the divisor is nonzero, the block goes IDLE → DONE directly with `quotient` = 0 and `remainder` = `dividend` (original sign), 1-cycle latency.
- `DIV_EARLY_OUT_EN` undefined: the comparator is omitted and such operands take the full N+1 cycles. Results are identical.

## Test plan
- Unsigned, WIDTH 32, `BITS_PER_CYCLE` 1: 100 / 7 gives `quotient` 14 and `remainder` 2. `out_valid` is first high 33 cycles after accept. Holding `out_ready` low 5 cycles keeps the values stable, then the block returns to IDLE.
- Signed, `BITS_PER_CYCLE` 2: −100 / 7 gives −14 and −2. 100 / −7 gives −14 and 2. `out_valid` appears after 17 cycles.
- Divide by zero: 0x1234 / 0 gives 0xFFFFFFFF and 0x1234. Signed 0x80000000 / 0xFFFFFFFF gives 0x80000000 and 0. Both produce `out_valid` 1 cycle after accept.
- Assert `flush` at CALC cycle 10: from the next cycle `out_valid` stays 0 and `in_ready` = 1. A new 9 / 3 issued afterwards gives 3 and 0.
- Drive `reset` low mid-CALC for 1 cycle: all outputs read 0 and `in_ready` = 1 on the next cycle. Change operands during CALC and confirm the result is unchanged.
- With `DIV_EARLY_OUT_EN`: 5 / 9 gives 0 and 5 after 1 cycle. Without the macro, the same operands give the same result after 33 cycles. Also run a randomized comparison against a reference model for all parameter legal values.
